// File: rtl/sa_core_skew.sv
// -----------------------------------------------------------------------------
// sa_core_skew
//
// Parametrised systolic MAC core. There are ROWS independent lanes. Each lane
// accumulates a*w products over a block of k_len beats. Operands enter as a
// wavefront: lane r sees a beat r cycles after lane 0. A finished result is
// held per lane behind a valid/ready handshake. If the collector has not
// popped a result that is about to be overwritten, the whole core stalls.
//
// Optional feature macro: SA_SAT_EN
//   Undefined : accumulation wraps modulo 2^AW, and there is no r_ovf port.
//   Defined   : accumulation saturates to the AW range of the beat's mode.
//               r_ovf reports per-lane overflow. It is sticky within a block,
//               written together with r_out, and cleared on pop.
//
// Ports
//   clk          clock, rising edge
//   rstn         asynchronous active-low reset
//   a_in         [ROWS][DW] activation operand per lane
//   w_in         [ROWS][DW] weight operand per lane
//   in_valid     operand beat valid (all lanes)
//   in_ready     core accepts a beat this cycle (combinational, ~stall)
//   k_len        beats per block, sampled on the first beat of a block (0 -> 1)
//   signed_mode  1 = two's-complement operands, 0 = unsigned (per beat)
//   r_out        [ROWS][AW] per-lane result
//   r_valid      [ROWS] per-lane result valid
//   r_ovf        [ROWS] per-lane overflow flag (SA_SAT_EN only)
//   r_ready      collector pops every lane whose r_valid is set
//   busy         a beat is in flight in the skew, or a block is partially summed
// -----------------------------------------------------------------------------
module sa_core_skew #(
    parameter int ROWS = 8,
    parameter int DW   = 8,
    parameter int AW   = 32,
    parameter int KW   = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [ROWS-1:0][DW-1:0]  a_in,
    input  logic [ROWS-1:0][DW-1:0]  w_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [KW-1:0]            k_len,
    input  logic                     signed_mode,
    output logic [ROWS-1:0][AW-1:0]  r_out,
    output logic [ROWS-1:0]          r_valid,
`ifdef SA_SAT_EN
    output logic [ROWS-1:0]          r_ovf,
`endif
    input  logic                     r_ready,
    output logic                     busy
);

    // Per-lane MAC input (the output of each lane's skew chain).
    logic [ROWS-1:0] mac_v;
    logic [ROWS-1:0] mac_s;
    logic [ROWS-1:0] mac_l;
    logic [DW-1:0]   mac_a [ROWS];
    logic [DW-1:0]   mac_w [ROWS];

    logic [ROWS-1:0] stall_lane;
    logic [ROWS-1:0] chain_busy;
    logic            stall;
    logic            accept;

    logic [KW-1:0]   count_reg;
    logic [KW-1:0]   klen_reg;
    logic [KW-1:0]   eff_k;
    logic            beat_last;

    // Lane 0's stall term uses the raw in_valid rather than the accepted beat.
    // This keeps in_ready free of a combinational loop through itself.
    assign stall    = |stall_lane;
    assign in_ready = rstn & ~stall;
    assign accept   = in_valid & in_ready;
    assign busy     = (|chain_busy) | (count_reg != '0);

    // ---------------------------------------------------------------------
    // Block counter. k_len is only looked at on the first beat of a block.
    // After that the latched value governs where the block ends.
    // ---------------------------------------------------------------------
    always_comb begin
        if (count_reg == '0) begin
            eff_k = (k_len == '0) ? KW'(1) : k_len;
        end else begin
            eff_k = klen_reg;
        end
        beat_last = (count_reg == (eff_k - KW'(1)));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_reg <= '0;
            klen_reg  <= '0;
        end else if (accept) begin
            if (count_reg == '0) begin
                klen_reg <= eff_k;
            end
            count_reg <= beat_last ? '0 : (count_reg + KW'(1));
        end
    end

    // ---------------------------------------------------------------------
    // Lanes
    // ---------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_lane

            if (gi == 0) begin : g_direct
                // Lane 0 computes on the beat as it is presented.
                assign mac_v[gi]      = in_valid;
                assign mac_s[gi]      = signed_mode;
                assign mac_l[gi]      = beat_last;
                assign mac_a[gi]      = a_in[gi];
                assign mac_w[gi]      = w_in[gi];
                assign chain_busy[gi] = 1'b0;
            end else begin : g_skew
                // A gi-deep chain that carries the operands and the tag.
                // Cycles with no accepted beat shift in a bubble (valid = 0).
                logic [DW-1:0] a_sk_reg [gi];
                logic [DW-1:0] w_sk_reg [gi];
                logic [gi-1:0] v_sk_reg;
                logic [gi-1:0] s_sk_reg;
                logic [gi-1:0] l_sk_reg;

                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) begin
                        for (int i = 0; i < gi; i++) begin
                            a_sk_reg[i] <= '0;
                            w_sk_reg[i] <= '0;
                        end
                        v_sk_reg <= '0;
                        s_sk_reg <= '0;
                        l_sk_reg <= '0;
                    end else if (!stall) begin
                        a_sk_reg[0] <= a_in[gi];
                        w_sk_reg[0] <= w_in[gi];
                        v_sk_reg[0] <= accept;
                        s_sk_reg[0] <= signed_mode;
                        l_sk_reg[0] <= beat_last;
                        for (int i = 1; i < gi; i++) begin
                            a_sk_reg[i] <= a_sk_reg[i-1];
                            w_sk_reg[i] <= w_sk_reg[i-1];
                            v_sk_reg[i] <= v_sk_reg[i-1];
                            s_sk_reg[i] <= s_sk_reg[i-1];
                            l_sk_reg[i] <= l_sk_reg[i-1];
                        end
                    end
                end

                assign mac_v[gi]      = v_sk_reg[gi-1];
                assign mac_s[gi]      = s_sk_reg[gi-1];
                assign mac_l[gi]      = l_sk_reg[gi-1];
                assign mac_a[gi]      = a_sk_reg[gi-1];
                assign mac_w[gi]      = w_sk_reg[gi-1];
                assign chain_busy[gi] = |v_sk_reg;
            end

            // ---------------- MAC and result holding ----------------
            logic signed [2*DW-1:0] prod_s;
            logic        [2*DW-1:0] prod_u;
            logic        [AW-1:0]   prod_ext;
            logic        [AW-1:0]   sum_val;
            logic        [AW-1:0]   acc_reg;
            logic        [AW-1:0]   out_reg;
            logic                   valid_reg;
`ifdef SA_SAT_EN
            logic                   ovf_now;
            logic                   ovf_acc_reg;
            logic                   ovf_out_reg;
`endif

            // The operands are widened to 2*DW before the multiply, so the
            // product is exact in both modes.
            assign prod_s = (2*DW)'($signed(mac_a[gi])) * (2*DW)'($signed(mac_w[gi]));
            assign prod_u = (2*DW)'(mac_a[gi]) * (2*DW)'(mac_w[gi]);

            always_comb begin
                if (mac_s[gi]) begin
                    prod_ext = AW'(prod_s);
                end else begin
                    prod_ext = AW'(prod_u);
                end
                sum_val = acc_reg + prod_ext;
`ifdef SA_SAT_EN
                ovf_now = 1'b0;
                if (mac_s[gi]) begin
                    // Signed overflow: both addends have the same sign,
                    // and the sum has the opposite sign.
                    if ((acc_reg[AW-1] == prod_ext[AW-1]) &&
                        (sum_val[AW-1] != acc_reg[AW-1])) begin
                        ovf_now = 1'b1;
                        sum_val = acc_reg[AW-1] ? {1'b1, {(AW-1){1'b0}}}
                                                : {1'b0, {(AW-1){1'b1}}};
                    end
                end else begin
                    // Unsigned carry-out shows up as a wrapped, smaller sum.
                    if (sum_val < acc_reg) begin
                        ovf_now = 1'b1;
                        sum_val = '1;
                    end
                end
`endif
            end

            // A lane stalls the core when it would overwrite an unpopped result.
            assign stall_lane[gi] = mac_v[gi] & mac_l[gi] & valid_reg & ~r_ready;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    acc_reg     <= '0;
                    out_reg     <= '0;
                    valid_reg   <= 1'b0;
`ifdef SA_SAT_EN
                    ovf_acc_reg <= 1'b0;
                    ovf_out_reg <= 1'b0;
`endif
                end else if (!stall) begin
                    if (r_ready) begin
                        valid_reg <= 1'b0;
`ifdef SA_SAT_EN
                        ovf_out_reg <= 1'b0;
`endif
                    end
                    if (mac_v[gi]) begin
                        if (mac_l[gi]) begin
                            // The write takes priority over a same-edge pop.
                            out_reg   <= sum_val;
                            valid_reg <= 1'b1;
                            acc_reg   <= '0;
`ifdef SA_SAT_EN
                            ovf_out_reg <= ovf_acc_reg | ovf_now;
                            ovf_acc_reg <= 1'b0;
`endif
                        end else begin
                            acc_reg <= sum_val;
`ifdef SA_SAT_EN
                            ovf_acc_reg <= ovf_acc_reg | ovf_now;
`endif
                        end
                    end
                end
            end

            assign r_out[gi]   = out_reg;
            assign r_valid[gi] = valid_reg;
`ifdef SA_SAT_EN
            assign r_ovf[gi]   = ovf_out_reg;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_sa_core_skew.sv
// -----------------------------------------------------------------------------
// tb_sa_core_skew
//
// Directed testbench for sa_core_skew.
//   Main instance  : ROWS=4, DW=8, AW=32. Covers wavefront timing, signed and
//                    unsigned products, stall on backpressure, reset in the
//                    middle of a block, and k_len = 0.
//   Small instance : ROWS=1, AW=16. Covers wrap versus saturation
//                    (SA_SAT_EN) at the result width.
// -----------------------------------------------------------------------------
module tb_sa_core_skew;

    logic                clk;
    logic                rstn;

    // main instance
    logic [3:0][7:0]     a_in;
    logic [3:0][7:0]     w_in;
    logic                in_valid;
    logic                in_ready;
    logic [7:0]          k_len;
    logic                signed_mode;
    logic [3:0][31:0]    r_out;
    logic [3:0]          r_valid;
    logic                r_ready;
    logic                busy;
`ifdef SA_SAT_EN
    logic [3:0]          r_ovf;
`endif

    // small instance
    logic [0:0][7:0]     a2;
    logic [0:0][7:0]     w2;
    logic                iv2;
    logic                ir2;
    logic [7:0]          k2;
    logic                s2;
    logic [0:0][15:0]    ro2;
    logic [0:0]          rv2;
    logic                rr2;
    logic                busy2;
`ifdef SA_SAT_EN
    logic [0:0]          ovf2;
`endif

    int n_vec;
    int n_err;

    sa_core_skew #(.ROWS(4), .DW(8), .AW(32), .KW(8)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .a_in        (a_in),
        .w_in        (w_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .k_len       (k_len),
        .signed_mode (signed_mode),
        .r_out       (r_out),
        .r_valid     (r_valid),
`ifdef SA_SAT_EN
        .r_ovf       (r_ovf),
`endif
        .r_ready     (r_ready),
        .busy        (busy)
    );

    sa_core_skew #(.ROWS(1), .DW(8), .AW(16), .KW(8)) dut_small (
        .clk         (clk),
        .rstn        (rstn),
        .a_in        (a2),
        .w_in        (w2),
        .in_valid    (iv2),
        .in_ready    (ir2),
        .k_len       (k2),
        .signed_mode (s2),
        .r_out       (ro2),
        .r_valid     (rv2),
`ifdef SA_SAT_EN
        .r_ovf       (ovf2),
`endif
        .r_ready     (rr2),
        .busy        (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input logic [7:0] a, input logic [7:0] w);
        for (int i = 0; i < 4; i++) begin
            a_in[i] = a;
            w_in[i] = w;
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rstn = 1'b0;
        set_ops(8'd0, 8'd0);
        in_valid = 1'b0; k_len = 8'd0; signed_mode = 1'b0; r_ready = 1'b0;
        a2[0] = 8'd0; w2[0] = 8'd0; iv2 = 1'b0; k2 = 8'd0; s2 = 1'b0; rr2 = 1'b0;

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_valid",    64'(r_valid), 64'(0));
        chk("rst_busy",     64'(busy), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out0",     64'(r_out[0]), 64'(0));
        rstn = 1'b1;
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'(1));

        // ---------------- T1: k_len=4, a=1, w=2, wavefront timing ----------------
        k_len = 8'd4; signed_mode = 1'b0; r_ready = 1'b1; set_ops(8'd1, 8'd2); in_valid = 1'b1;
        tick();
        chk("t1_busy_e1",  64'(busy), 64'(1));
        chk("t1_valid_e1", 64'(r_valid), 64'(0));
        tick(); tick();
        chk("t1_valid_e3", 64'(r_valid), 64'(0));
        tick(); in_valid = 1'b0;
        chk("t1_valid_e4", 64'(r_valid), 64'(4'b0001));
        chk("t1_out0",     64'(r_out[0]), 64'(8));
`ifdef SA_SAT_EN
        chk("t1_ovf",      64'(r_ovf), 64'(0));
`endif
        tick();
        chk("t1_valid_e5", 64'(r_valid), 64'(4'b0010));
        chk("t1_out1",     64'(r_out[1]), 64'(8));
        tick();
        chk("t1_valid_e6", 64'(r_valid), 64'(4'b0100));
        chk("t1_out2",     64'(r_out[2]), 64'(8));
        tick();
        chk("t1_valid_e7", 64'(r_valid), 64'(4'b1000));
        chk("t1_out3",     64'(r_out[3]), 64'(8));
        tick();
        chk("t1_valid_e8", 64'(r_valid), 64'(0));
        chk("t1_busy_e8",  64'(busy), 64'(0));

        // ---------------- T2: signed / unsigned, a=0xFD, w=5, k_len=2 ----------------
        k_len = 8'd2; signed_mode = 1'b1; set_ops(8'hFD, 8'd5); in_valid = 1'b1;
        tick(); tick(); in_valid = 1'b0;
        chk("t2s_valid", 64'(r_valid), 64'(4'b0001));
        chk("t2s_out0",  64'(r_out[0]), 64'(32'hFFFF_FFE2));
        tick(); tick(); tick(); tick();
        chk("t2s_out3",  64'(r_out[3]), 64'(32'hFFFF_FFE2));
        chk("t2s_drain", 64'(r_valid), 64'(0));
        signed_mode = 1'b0; in_valid = 1'b1;
        tick(); tick(); in_valid = 1'b0;
        chk("t2u_out0",  64'(r_out[0]), 64'(2530));
        tick(); tick(); tick(); tick();
        chk("t2u_out3",  64'(r_out[3]), 64'(2530));

        // ---------------- T3: backpressure stall, k_len=1 ----------------
        r_ready = 1'b0; k_len = 8'd1; set_ops(8'd2, 8'd3); in_valid = 1'b1;
        #1;
        chk("t3_ready_pre", 64'(in_ready), 64'(1));
        tick();
        chk("t3_valid_e1",  64'(r_valid), 64'(4'b0001));
        chk("t3_out0_e1",   64'(r_out[0]), 64'(6));
        set_ops(8'd4, 8'd5);
        #1;
        chk("t3_stall",     64'(in_ready), 64'(0));
        tick(); tick();
        chk("t3_stall_hold", 64'(in_ready), 64'(0));
        chk("t3_valid_hold", 64'(r_valid), 64'(4'b0001));
        chk("t3_out0_hold",  64'(r_out[0]), 64'(6));
        chk("t3_busy_hold",  64'(busy), 64'(1));
        r_ready = 1'b1;
        #1;
        chk("t3_release",   64'(in_ready), 64'(1));
        tick(); in_valid = 1'b0;
        chk("t3_valid_e4",  64'(r_valid), 64'(4'b0011));
        chk("t3_out0_2nd",  64'(r_out[0]), 64'(20));
        chk("t3_out1_1st",  64'(r_out[1]), 64'(6));
        tick();
        chk("t3_valid_e5",  64'(r_valid), 64'(4'b0110));
        chk("t3_out1_2nd",  64'(r_out[1]), 64'(20));
        chk("t3_out2_1st",  64'(r_out[2]), 64'(6));
        tick();
        chk("t3_valid_e6",  64'(r_valid), 64'(4'b1100));
        chk("t3_out3_1st",  64'(r_out[3]), 64'(6));
        tick();
        chk("t3_valid_e7",  64'(r_valid), 64'(4'b1000));
        chk("t3_out3_2nd",  64'(r_out[3]), 64'(20));
        tick();
        chk("t3_valid_e8",  64'(r_valid), 64'(0));

        // ---------------- T4: reset in the middle of a block ----------------
        k_len = 8'd4; set_ops(8'd1, 8'd1); in_valid = 1'b1;
        tick(); tick();
        chk("t4_busy_mid",  64'(busy), 64'(1));
        in_valid = 1'b0; rstn = 1'b0;
        #1;
        chk("t4_rst_valid", 64'(r_valid), 64'(0));
        chk("t4_rst_busy",  64'(busy), 64'(0));
        chk("t4_rst_ready", 64'(in_ready), 64'(0));
        chk("t4_rst_out0",  64'(r_out[0]), 64'(0));
        tick();
        rstn = 1'b1; in_valid = 1'b1;
        tick(); tick(); tick(); tick(); in_valid = 1'b0;
        chk("t4_valid",     64'(r_valid), 64'(4'b0001));
        chk("t4_out0",      64'(r_out[0]), 64'(4));
        tick(); tick(); tick();
        chk("t4_out3",      64'(r_out[3]), 64'(4));

        // ---------------- T5: k_len=0 behaves as 1 ----------------
        tick();
        k_len = 8'd0; set_ops(8'd3, 8'd3); in_valid = 1'b1;
        tick();
        chk("t5_valid_e1", 64'(r_valid), 64'(4'b0001));
        chk("t5_out0_e1",  64'(r_out[0]), 64'(9));
        tick();
        chk("t5_valid_e2", 64'(r_valid), 64'(4'b0011));
        tick(); in_valid = 1'b0;
        chk("t5_valid_e3", 64'(r_valid), 64'(4'b0111));
        chk("t5_out0_e3",  64'(r_out[0]), 64'(9));
        tick();
        chk("t5_valid_e4", 64'(r_valid), 64'(4'b1110));
        tick();
        chk("t5_valid_e5", 64'(r_valid), 64'(4'b1100));
        tick();
        chk("t5_valid_e6", 64'(r_valid), 64'(4'b1000));
        chk("t5_out3",     64'(r_out[3]), 64'(9));
        tick();
        chk("t5_valid_e7", 64'(r_valid), 64'(0));
        chk("t5_busy_e7",  64'(busy), 64'(0));

        // ---------------- T6: AW=16, unsigned 255*255 twice ----------------
        k2 = 8'd2; s2 = 1'b0; a2[0] = 8'd255; w2[0] = 8'd255; rr2 = 1'b1; iv2 = 1'b1;
        tick(); tick(); iv2 = 1'b0;
        chk("t6_valid", 64'(rv2), 64'(1));
`ifdef SA_SAT_EN
        chk("t6_out_sat", 64'(ro2[0]), 64'(16'hFFFF));
        chk("t6_ovf",     64'(ovf2), 64'(1));
`else
        chk("t6_out_wrap", 64'(ro2[0]), 64'(64514));
`endif
        tick();
        chk("t6_pop", 64'(rv2), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sa_core_skew.md
Name: sa_core_skew

Overview:
- Parametrised next-generation systolic MAC core: ROWS independent lanes, each accumulating products of operand pairs over a runtime-programmable block length k_len.
- Operands enter skewed: lane r sees its beat r cycles after lane 0, forming the systolic wavefront.
- Completed results are held per lane behind a valid/ready output handshake, with whole-core stall on backpressure.
- Sits between the operand feeders and the result collector, in the position of the fixed-width 8-row core.

Parameters:
- ROWS, 8, lane count (>=1)
- DW, 8, operand width
- AW, 32, accumulator/result width (>= 2*DW)
- KW, 8, width of k_len

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- a_in  in  ROWS x DW  activation operand per lane
- w_in  in  ROWS x DW  weight operand per lane
- in_valid  in  1  operand beat valid, all lanes
- in_ready  out  1  core accepts a beat this cycle
- k_len  in  KW  beats per accumulation block; sampled on the first beat of each block
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled per beat
- r_out  out  ROWS x AW  per-lane result
- r_valid  out  ROWS  per-lane result valid
- r_ready  in  1  collector pops every lane whose r_valid is set
- busy  out  1  a beat is in flight in the skew, or a block is partially accumulated

Behaviour:
- Reset (rstn low, asynchronous):
  - Skew registers, accumulators, block counter, r_out, r_valid and busy all clear to 0.
  - in_ready is 0 while rstn is low.
- Accept: a beat is accepted on a rising edge with in_valid && in_ready. Each beat carries a tag {valid, signed_mode, last} through the skew.
- Block counter:
  - Counts accepted beats.
  - On beat 0 it latches k_len; k_len = 0 is treated as 1.
  - last = (count == latched k_len - 1); the counter wraps to 0 after a last beat.
- Skew:
  - Lane r has an r-deep register chain; lane 0 has none.
  - The chain shifts on every non-stalled edge and inserts bubbles when no beat is accepted, so draining needs no extra control.
- MAC:
  - On a non-stalled edge where lane r's skew output is valid, product = a*w (2*DW bits, signed or unsigned per tag), extended to AW. acc <= acc + product.
  - If the tag has last set: r_out[r] <= acc + product, r_valid[r] <= 1, acc <= 0.
- Arithmetic: wraps modulo 2^AW (see SAT_EN).
- Latency: for the last beat accepted on edge E, r_valid[r] rises after the (r)th non-stalled edge following E; lane 0 rises after E itself.
- Pop and write:
  - r_ready = 1 on an edge clears all set r_valid bits.
  - If a lane writes a new result on that same edge, its r_valid stays 1 and holds the new value.
- Stall:
  - stall = some lane has a valid last tag at its MAC input, r_valid for that lane is 1, and r_ready = 0.
  - While stalled, skew, accumulators and counter freeze; in_ready = ~stall (combinational); no result is ever overwritten unpopped.
- busy = any valid skew tag, or block counter != 0.
- Reset mid-block: all partial sums and in-flight beats are discarded. The first beat after reset starts a new block.

Optional Feature:
- Macro: SA_SAT_EN.
- Defined:
  - Accumulation saturates to the AW range of the tag's mode: signed [-2^(AW-1), 2^(AW-1)-1], unsigned [0, 2^AW-1].
  - An extra output r_ovf (ROWS bits) reports per-lane overflow. It is sticky within a block, written with r_out, and cleared with r_valid on pop.
- Undefined: wrap-around arithmetic and no r_ovf port.

Test Plan:
- ROWS=4, k_len=4, a=1, w=2 on all lanes, 4 consecutive beats, r_ready=1 -> r_valid[r] pulses one cycle each, staggered by one cycle per lane; r_out = 8; busy drops after lane 3 pops.
- signed_mode=1, a=0xFD, w=5, k_len=2 -> r_out = 0xFFFFFFE2 (-30); same with signed_mode=0 -> 2530.
- r_ready=0, k_len=1, two back-to-back beats -> in_ready falls when the second last-tag reaches lane 0 and stays low until r_ready=1; both results (first, then second) are read intact.
- rstn pulsed low after 2 of 4 beats -> r_valid=0, busy=0 immediately. A new block of k_len=4 with a=1, w=1 yields 4, not 6.
- k_len=0, 3 beats of a=3, w=3 -> three results of 9 per lane.
- SA_SAT_EN, AW=16, unsigned, a=w=255, k_len=2 -> r_out = 0xFFFF, r_ovf=1. Without the macro -> r_out = 64514.
